osd_u8g2_tx: RTL
================

// Module: osd_u8g2_tx
// PURPOSE
//  Transmitter for the 128x64 u8g2-layout OSD byte stream (strobe/start/data). Keeps a local
//  1024-byte shadow of the OSD framebuffer plus a per-tile dirty map. Serialises show/hide
//  commands and dirty 8-byte tiles into framed byte sequences for the OSD overlay receiver.
//  Sits between the MCU/host register interface and the OSD overlay in the video path.
// PARAMETERS
//  GAP        1         minimum idle clocks between two output strobes (0 = back-to-back)
//  HIDE_TICKS 50000000  idle clocks before auto-hide (used only with OSD_TX_AUTOHIDE_EN)
// PORTS
//  clk              in   1   system clock; all logic on rising edge
//  reset            in   1   asynchronous, active-high reset
//  wr_en            in   1   host write strobe into shadow buffer
//  wr_addr          in   10  byte address; tile = wr_addr[9:3], byte-in-tile = wr_addr[2:0]
//  wr_data          in   8   byte value; bit n = pixel row n of the 8-row tile column
//  show_req         in   1   one-cycle request to send a show/hide command
//  show_val         in   1   1 = show, 0 = hide; sampled with show_req
//  busy             out  1   a frame is in progress or work is pending
//  osd_visible      out  1   value of the last show/hide command transmitted
//  data_out_strobe  out  1   one-cycle byte-valid pulse
//  data_out_start   out  1   qualifies strobe: byte is a command byte (frame start)
//  data_out         out  8   byte value, valid only while data_out_strobe=1
// BEHAVIOUR
//  - Reset (async): all outputs 0, dirty map all 0, show pending 0, FSM IDLE, pace counter 0.
//    Shadow RAM is not cleared. Reset mid-frame truncates the frame. The receiver resyncs on
//    the next start byte.
//  - All outputs are registered. data_out_start=1 only when data_out_strobe=1.
//  - Write: wr_en stores wr_data at wr_addr and sets dirty[wr_addr[9:3]] on the next edge.
//  - Show: show_req sets show_pend and latches show_val. A repeat request while pending
//    overwrites the value; only one command is sent.
//  - Frame CMD:  strobe+start data=8'h01, then strobe data={7'b0,val}.
//    osd_visible<=val with the second byte.
//  - Frame TILE: strobe+start data=8'h02, then strobe data={1'b0,tile[6:0]},
//    then 8 strobes data=buf[{tile,3'd0}..{tile,3'd7}] in ascending order.
//  - Pacing: after a strobe, the next strobe is emitted no earlier than GAP+1 clocks later.
//    The FSM holds state while pacing.
//  - FSM: IDLE -> CMD_HDR -> CMD_ARG -> IDLE; IDLE -> TILE_HDR -> TILE_ADDR -> TILE_DATA(x8) -> IDLE.
//    In IDLE, show_pend has priority over tiles. Otherwise scan_ptr (7 bit) tests one tile per clock.
//    If dirty, that tile is latched. If clean, scan_ptr increments and wraps 127->0.
//    After a tile frame, scan continues at tile+1 (round-robin, no starvation).
//  - Dirty clear: dirty[tile] clears in the TILE_ADDR strobe cycle.
//    A wr_en to the same tile in the same cycle wins (bit stays set).
//    A later write sets it again, so the tile is resent.
//  - RAM read: synchronous, 1-clock latency. Prefetch the address one cycle ahead so data
//    bytes are spaced by exactly GAP+1 clocks. A write racing a read may return old data.
//    The dirty bit guarantees a consistent resend.
//  - Latency: show_req in IDLE (no pacing) -> header strobe 2 clocks later.
//    Full TILE frame = 10 strobes = 10*(GAP+1)-GAP clocks.
//  - busy = (state!=IDLE) | show_pend | (|dirty).
// CONFIGURATION
//  OSD_TX_AUTOHIDE_EN defined:
//    - A 32-bit idle counter reloads on wr_en or on show_req with show_val=1.
//    - When the counter reaches HIDE_TICKS while osd_visible=1 and show_pend=0, the block
//      raises show_pend with val=0. The counter then holds until the next reload.
//  OSD_TX_AUTOHIDE_EN undefined: no counter; osd_visible changes only via show_req.
// STRUCTURE
//  Package osd_pkg:
//    - OSD_CMD_ENABLE=8'h01, OSD_CMD_TILE=8'h02
//    - OSD_TILES=128, OSD_TILE_BYTES=8, OSD_BUF_BYTES=1024
//    - tx state enum (IDLE, CMD_HDR, CMD_ARG, TILE_HDR, TILE_ADDR, TILE_DATA)
//  Sub-module osd_tile_ram: 1024x8 simple dual-port, write port host, sync read port tx.
// TESTING
//  - Reset then idle 200 clk -> no strobes, busy=0, osd_visible=0.
//  - show_req,val=1 (GAP=1) -> strobes (start,01),(00... wait -> (start,01),(01); osd_visible=1;
//    strobes 2 clk apart.
//  - Write 8'hA5 to addr 10'h3F8 -> frame (start,02),(7F), then 8 bytes with byte0=A5,
//    others = RAM content.
//  - Dirty tiles 5 and 3 with scan_ptr=4 -> tile 5 sent before tile 3; each exactly once.
//  - Rewrite tile 5 during its TILE_DATA -> tile 5 sent twice; second copy has the new byte.
//  - With OSD_TX_AUTOHIDE_EN, HIDE_TICKS=100: show, then idle -> (start,01),(00)
//    ~100 clk later; osd_visible=0.

Source files
------------

// File: rtl/osd_pkg.sv
// Shared constants and types for the u8g2-layout OSD byte-stream transmitter.
package osd_pkg;

    // Command bytes that open a frame (sent with data_out_start=1)
    localparam logic [7:0] OSD_CMD_ENABLE = 8'h01;
    localparam logic [7:0] OSD_CMD_TILE   = 8'h02;

    // Framebuffer geometry: 128x64 pixels = 128 tiles of 8 column bytes
    localparam int OSD_TILES      = 128;
    localparam int OSD_TILE_BYTES = 8;
    localparam int OSD_BUF_BYTES  = 1024;

    // Transmit sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD_HDR   = 3'd1,
        ST_CMD_ARG   = 3'd2,
        ST_TILE_HDR  = 3'd3,
        ST_TILE_ADDR = 3'd4,
        ST_TILE_DATA = 3'd5
    } tx_state_t;

endpackage

// File: rtl/osd_tile_ram.sv
// 1024x8 simple dual-port shadow of the OSD framebuffer.
// Write port belongs to the host, the synchronous read port to the transmitter.
// Contents are deliberately not reset.
module osd_tile_ram
    import osd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_wr_en,
    input  logic [9:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic [9:0] i_rd_addr,
    output logic [7:0] o_rd_data
);

    logic [7:0] r_mem [0:OSD_BUF_BYTES-1];

    // Host write and 1-clock-latency transmit read (read returns old data on a same-address race)
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/osd_u8g2_tx.sv
// OSD byte-stream transmitter: shadow framebuffer + per-tile dirty map, serialised
// into show/hide command frames and 8-byte tile frames (strobe/start/data).
// Optional build macro OSD_TX_AUTOHIDE_EN adds an idle counter that auto-hides the OSD
// after HIDE_TICKS clocks without host activity.
module osd_u8g2_tx
    import osd_pkg::*;
#(
    parameter int GAP        = 1,
    parameter int HIDE_TICKS = 50000000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr_en,
    input  logic [9:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic       i_show_req,
    input  logic       i_show_val,
    output logic       o_busy,
    output logic       o_osd_visible,
    output logic       o_data_out_strobe,
    output logic       o_data_out_start,
    output logic [7:0] o_data_out
);

    tx_state_t             r_state;
    logic [OSD_TILES-1:0]  r_dirty;
    logic [6:0]            r_scan_ptr;
    logic [6:0]            r_tile;
    logic [2:0]            r_idx;
    logic                  r_show_pend;
    logic                  r_show_val;
    logic                  r_cmd_val;
    logic [15:0]           r_pace;

    logic                  w_pace_ok;
    logic                  w_fire;
    logic [9:0]            w_rd_addr;
    logic [7:0]            w_rd_data;
    logic [6:0]            w_wr_tile;
    logic                  w_autohide;

    assign w_pace_ok = (r_pace == 16'd0);
    assign w_wr_tile = i_wr_addr[9:3];

    // A strobe is emitted this cycle when a frame state is active and pacing has expired
    always_comb begin
        w_fire = 1'b0;
        case (r_state)
            ST_CMD_HDR, ST_CMD_ARG, ST_TILE_HDR, ST_TILE_ADDR, ST_TILE_DATA: w_fire = w_pace_ok;
            default:                                                           w_fire = 1'b0;
        endcase
    end

    // Prefetch: when a data byte goes out, address the next one so it is ready GAP+1 clocks later
    always_comb begin
        w_rd_addr = {r_tile, r_idx};
        if (w_fire && (r_state == ST_TILE_DATA)) begin
            w_rd_addr = {r_tile, r_idx + 3'd1};
        end else begin
            w_rd_addr = {r_tile, r_idx};
        end
    end

    osd_tile_ram u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

`ifdef OSD_TX_AUTOHIDE_EN
    logic [31:0] r_idle_cnt;

    // Idle counter: reloads on host activity that keeps the OSD alive, saturates at HIDE_TICKS
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idle_cnt <= 32'd0;
        end else if (i_wr_en || (i_show_req && i_show_val)) begin
            r_idle_cnt <= 32'd0;
        end else if (r_idle_cnt != 32'(HIDE_TICKS)) begin
            r_idle_cnt <= r_idle_cnt + 32'd1;
        end else begin
            r_idle_cnt <= r_idle_cnt;
        end
    end

    // Only request a hide from IDLE so an in-flight command cannot trigger a duplicate
    assign w_autohide = (r_idle_cnt == 32'(HIDE_TICKS)) && o_osd_visible &&
                        !r_show_pend && (r_state == ST_IDLE);
`else
    logic w_unused_hide_ticks;
    assign w_unused_hide_ticks = ^32'(HIDE_TICKS);
    assign w_autohide          = 1'b0;
`endif

    // Inter-strobe pacing: after each strobe hold off GAP clocks
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pace <= 16'd0;
        end else if (w_fire) begin
            r_pace <= 16'(GAP);
        end else if (r_pace != 16'd0) begin
            r_pace <= r_pace - 16'd1;
        end else begin
            r_pace <= r_pace;
        end
    end

    // Pending show/hide request; a new request overwrites the value, host request beats auto-hide
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_show_pend <= 1'b0;
            r_show_val  <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && r_show_pend) begin
                r_show_pend <= 1'b0;
            end
            if (w_autohide) begin
                r_show_pend <= 1'b1;
                r_show_val  <= 1'b0;
            end
            if (i_show_req) begin
                r_show_pend <= 1'b1;
                r_show_val  <= i_show_val;
            end
        end
    end

    // Dirty map: cleared when the tile address goes out, a same-cycle write keeps it set
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dirty <= '0;
        end else begin
            if (w_fire && (r_state == ST_TILE_ADDR)) begin
                r_dirty[r_tile] <= 1'b0;
            end
            if (i_wr_en) begin
                r_dirty[w_wr_tile] <= 1'b1;
            end
        end
    end

    // Frame sequencer with registered strobe/start/data/visible outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state           <= ST_IDLE;
            r_scan_ptr        <= 7'd0;
            r_tile            <= 7'd0;
            r_idx             <= 3'd0;
            r_cmd_val         <= 1'b0;
            o_osd_visible     <= 1'b0;
            o_data_out_strobe <= 1'b0;
            o_data_out_start  <= 1'b0;
            o_data_out        <= 8'h00;
        end else begin
            o_data_out_strobe <= 1'b0;
            o_data_out_start  <= 1'b0;
            o_data_out        <= 8'h00;
            case (r_state)
                ST_IDLE: begin
                    if (r_show_pend) begin
                        r_cmd_val <= r_show_val;
                        r_state   <= ST_CMD_HDR;
                    end else if (r_dirty[r_scan_ptr]) begin
                        r_tile  <= r_scan_ptr;
                        r_idx   <= 3'd0;
                        r_state <= ST_TILE_HDR;
                    end else begin
                        r_scan_ptr <= r_scan_ptr + 7'd1;
                    end
                end
                ST_CMD_HDR: begin
                    if (w_pace_ok) begin
                        o_data_out_strobe <= 1'b1;
                        o_data_out_start  <= 1'b1;
                        o_data_out        <= OSD_CMD_ENABLE;
                        r_state           <= ST_CMD_ARG;
                    end
                end
                ST_CMD_ARG: begin
                    if (w_pace_ok) begin
                        o_data_out_strobe <= 1'b1;
                        o_data_out        <= {7'b0, r_cmd_val};
                        o_osd_visible     <= r_cmd_val;
                        r_state           <= ST_IDLE;
                    end
                end
                ST_TILE_HDR: begin
                    if (w_pace_ok) begin
                        o_data_out_strobe <= 1'b1;
                        o_data_out_start  <= 1'b1;
                        o_data_out        <= OSD_CMD_TILE;
                        r_state           <= ST_TILE_ADDR;
                    end
                end
                ST_TILE_ADDR: begin
                    if (w_pace_ok) begin
                        o_data_out_strobe <= 1'b1;
                        o_data_out        <= {1'b0, r_tile};
                        r_state           <= ST_TILE_DATA;
                    end
                end
                ST_TILE_DATA: begin
                    if (w_pace_ok) begin
                        o_data_out_strobe <= 1'b1;
                        o_data_out        <= w_rd_data;
                        if (r_idx == 3'(OSD_TILE_BYTES - 1)) begin
                            r_scan_ptr <= r_tile + 7'd1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Busy flag: frame in flight or any work outstanding
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_busy <= 1'b0;
        end else begin
            o_busy <= (r_state != ST_IDLE) | r_show_pend | (|r_dirty);
        end
    end

endmodule
